// File: rtl/seq_sm_divider.sv
// Sequential sign-magnitude divider: 4-bit magnitudes plus sign bits, restoring
// division at one quotient bit per clock, with a registered six-digit
// seven-segment display of the quotient and remainder.
module seq_sm_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  bits,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [4:0]  quotient,
  output logic [4:0]  remainder,
  output logic [41:0] display
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;
  localparam logic [6:0] SEG_E     = 7'b1001111;

  state_t      state, state_nxt;
  logic [1:0]  cnt;

  // Operand and working registers (data only, no reset needed)
  logic        dvd_sign, dvs_sign;
  logic [3:0]  dvd_sr;
  logic [3:0]  dvs_mag;
  logic [3:0]  prem;
  logic [3:0]  qsr;

  // Restoring-step combinational signals
  logic [4:0]  prem_shift;
  logic        q_bit;
  logic [3:0]  diff;
  logic [3:0]  prem_nxt;
  logic [3:0]  q_nxt;
  logic        launch;
  logic        last_step;
  logic        q_sign;
  logic        r_sign;

  // Hex digit to active-high a..g segment pattern
  function automatic logic [6:0] seg_hex(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_BLANK;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      4'hF: s = 7'b1000111;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Full 42-bit display image for a finished division
  function automatic logic [41:0] build_display(input logic qs, input logic [3:0] qm,
                                                input logic rs, input logic [3:0] rm,
                                                input logic dz);
    logic [41:0] d;
    if (dz)
      d = {SEG_BLANK, SEG_E, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
    else
      d = {(qs ? SEG_MINUS : SEG_BLANK), seg_hex(qm), SEG_BLANK,
           (rs ? SEG_MINUS : SEG_BLANK), SEG_BLANK, seg_hex(rm)};
    return d;
  endfunction

  assign launch    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (cnt == 2'd3);
  assign busy      = (state == RUN);

  // One restoring step: bring in the next dividend bit, trial-subtract, keep or restore.
  // A divisor of zero always "fits", giving quotient F and remainder = dividend.
  always_comb begin
    prem_shift = {prem, dvd_sr[3]};
    q_bit      = (prem_shift >= {1'b0, dvs_mag});
    diff       = prem_shift[3:0] - dvs_mag;
    prem_nxt   = q_bit ? diff : prem_shift[3:0];
    q_nxt      = {qsr[2:0], q_bit};
    q_sign     = (dvd_sign ^ dvs_sign) & (|q_nxt);
    r_sign     = dvd_sign & (|prem_nxt);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: four RUN cycles per division
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= 2'd0;
    else if (launch) cnt <= 2'd0;
    else if (busy)   cnt <= cnt + 2'd1;
  end

  // Operand latch at launch, then shift the dividend and accumulate per step
  always_ff @(posedge clk) begin
    if (launch) begin
      dvd_sign <= bits[9];
      dvd_sr   <= bits[8:5];
      dvs_sign <= bits[4];
      dvs_mag  <= bits[3:0];
      prem     <= 4'd0;
      qsr      <= 4'd0;
    end else if (busy) begin
      dvd_sr   <= {dvd_sr[2:0], 1'b0};
      prem     <= prem_nxt;
      qsr      <= q_nxt;
    end
  end

  // Result, flag and display registers, updated only on the final step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= 5'd0;
      remainder <= 5'd0;
      display   <= 42'd0;
    end else begin
      done <= last_step;
      if (last_step) begin
        div_zero  <= (dvs_mag == 4'd0);
        quotient  <= {q_sign, q_nxt};
        remainder <= {r_sign, prem_nxt};
        display   <= build_display(q_sign, q_nxt, r_sign, prem_nxt, (dvs_mag == 4'd0));
      end
    end
  end

endmodule

// File: tb/tb_seq_sm_divider.sv
// Directed testbench for seq_sm_divider with hand-computed expected values.
module tb_seq_sm_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  bits;
  logic        busy, done, div_zero;
  logic [4:0]  quotient, remainder;
  logic [41:0] display;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] B  = 7'b0000000;
  localparam logic [6:0] M  = 7'b0000001;
  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] SE = 7'b1001111;

  seq_sm_divider dut (
    .clk(clk), .rst(rst), .start(start), .bits(bits),
    .busy(busy), .done(done), .div_zero(div_zero),
    .quotient(quotient), .remainder(remainder), .display(display)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with operands b; return cycles from start edge until done is seen
  task automatic run_op(input logic [9:0] b, output int lat);
    bits  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int done_cnt;

    rst = 1'b1; start = 1'b0; bits = 10'd0;
    #12;
    check("rst_busy",     42'(busy),      42'd0);
    check("rst_done",     42'(done),      42'd0);
    check("rst_divzero",  42'(div_zero),  42'd0);
    check("rst_quot",     42'(quotient),  42'd0);
    check("rst_rem",      42'(remainder), 42'd0);
    check("rst_display",  display,        42'd0);
    tick();
    rst = 1'b0;
    tick();

    // 13 / 3
    run_op(10'b0_1101_0_0011, lat);
    check("p13d3_lat",  42'(lat),       42'd4);
    check("p13d3_q",    42'(quotient),  42'h04);
    check("p13d3_r",    42'(remainder), 42'h01);
    check("p13d3_dz",   42'(div_zero),  42'd0);
    check("p13d3_busy", 42'(busy),      42'd0);
    check("p13d3_disp", display,        {B, S4, B, B, B, S1});
    tick();
    check("p13d3_done_pulse", 42'(done), 42'd0);
    check("p13d3_disp_hold",  display,   {B, S4, B, B, B, S1});

    // -13 / 3
    run_op(10'b1_1101_0_0011, lat);
    check("n13d3_lat",  42'(lat),       42'd4);
    check("n13d3_q",    42'(quotient),  42'h14);
    check("n13d3_r",    42'(remainder), 42'h11);
    check("n13d3_disp", display,        {M, S4, B, M, B, S1});

    // 7 / -8: zero quotient keeps a positive sign
    run_op(10'b0_0111_1_1000, lat);
    check("p7dn8_q",    42'(quotient),  42'h00);
    check("p7dn8_r",    42'(remainder), 42'h07);
    check("p7dn8_disp", display,        {B, S0, B, B, B, S7});

    // -15 / 0
    run_op(10'b1_1111_0_0000, lat);
    check("dz_lat",  42'(lat),       42'd4);
    check("dz_flag", 42'(div_zero),  42'd1);
    check("dz_q",    42'(quotient),  42'h1F);
    check("dz_r",    42'(remainder), 42'h1F);
    check("dz_disp", display,        {B, SE, B, B, B, B});
    tick(); tick(); tick();
    check("dz_flag_hold", 42'(div_zero), 42'd1);
    check("dz_disp_hold", display,       {B, SE, B, B, B, B});

    // 6 / 2 clears the sticky divide-by-zero flag
    run_op(10'b0_0110_0_0010, lat);
    check("p6d2_dz",   42'(div_zero),  42'd0);
    check("p6d2_q",    42'(quotient),  42'h03);
    check("p6d2_r",    42'(remainder), 42'h00);
    check("p6d2_disp", display,        {B, S3, B, B, B, S0});

    // 9 / 2 with start re-pulsed and operands changed while busy
    tick();
    bits  = 10'b0_1001_0_0010;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (i == 1 || i == 2) begin
        bits  = 10'b1_1111_0_0011;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("ign_busy_cycles", 42'(busy_cnt),  42'd4);
    check("ign_done_count",  42'(done_cnt),  42'd1);
    check("ign_q",           42'(quotient),  42'h04);
    check("ign_r",           42'(remainder), 42'h01);

    // Reset in the middle of a division
    bits  = 10'b0_1101_0_0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 42'(busy),     42'd0);
    check("mid_rst_done", 42'(done),     42'd0);
    check("mid_rst_disp", display,       42'd0);
    check("mid_rst_q",    42'(quotient), 42'd0);
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("mid_rst_no_done", 42'(done_cnt), 42'd0);
    check("mid_rst_disp_hold", display,     42'd0);
    run_op(10'b0_1101_0_0011, lat);
    check("post_rst_lat",  42'(lat),       42'd4);
    check("post_rst_q",    42'(quotient),  42'h04);
    check("post_rst_r",    42'(remainder), 42'h01);
    check("post_rst_disp", display,        {B, S4, B, B, B, S1});

    // start held high restarts on the first idle edge after done
    tick();
    bits  = 10'b0_0110_0_0010;
    start = 1'b1;
    tick();
    lat = 0;
    while (!done && lat < 12) begin
      tick();
      lat++;
    end
    check("held_lat", 42'(lat), 42'd4);
    tick();
    check("held_restart_busy", 42'(busy), 42'd1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 12) begin
      tick();
      lat++;
    end
    check("held_second_lat", 42'(lat),      42'd4);
    check("held_q",          42'(quotient), 42'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
